spike_rate_encoder: RTL

//  Upstream stage of the IF neuron layer: converts a latched vector of pixel intensities into
//  per-input spike trains over a fixed window of NUM_TIMESTEPS steps (rate coding).
//  One bit per input per timestep feeds the neuron layer's spike_in bus.

---
 rtl/snn_pkg.sv | 41 ++++
 rtl/spike_rate_encoder_if.sv | 26 ++
 rtl/spike_lane_gen.sv | 74 +++++++
 rtl/spike_rate_encoder.sv | 98 +++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, LFSR taps and sizing helper for the spike rate encoder
// Contents: enc_state_t (IDLE, ENCODE), lfsr_taps() Galois tap masks per width, clog2() sizing helper.
package snn_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ENCODE = 1'b1
   } enc_state_t;

   // Right-shifting Galois tap masks for maximal-length sequences.
   // Bit (t-1) is set for each polynomial term x^t.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_B400;
         24:      return 32'h00E1_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_B400;
      endcase
   endfunction

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// rtl/spike_rate_encoder_if.sv - image load and spike stream bundle of the spike rate encoder
// Signals: pixel_in/load_valid/load_ready (image load), spike_out/spike_valid/spike_ready (spike stream),
//          neuron_clear and done (single-cycle pulses). slave = encoder side, master = feeding/consuming side.
interface spike_rate_encoder_if #(
   parameter int NUM_INPUTS  = 4,
   parameter int PIXEL_WIDTH = 8
);
   logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_in;
   logic                              load_valid;
   logic                              load_ready;
   logic [NUM_INPUTS-1:0]             spike_out;
   logic                              spike_valid;
   logic                              spike_ready;
   logic                              neuron_clear;
   logic                              done;

   modport master (
      output pixel_in, load_valid, spike_ready,
      input  load_ready, spike_out, spike_valid, neuron_clear, done
   );

   modport slave (
      input  pixel_in, load_valid, spike_ready,
      output load_ready, spike_out, spike_valid, neuron_clear, done
   );
endinterface

// File: rtl/spike_lane_gen.sv
// rtl/spike_lane_gen.sv - one spike lane: latched pixel plus random or phase-accumulator generator
// Ports: clk, rst (sync active-low), load (latch pixel, restart generator), step (advance generator),
//        pixel (intensity to latch), spike (spike bit for the current step).
// Build option: SPIKE_ENC_DETERMINISTIC_EN selects the phase accumulator instead of the LFSR.
module spike_lane_gen
   import snn_pkg::*;
#(
   parameter int                    PIXEL_WIDTH = 8,
   parameter int                    LFSR_WIDTH  = 16,
   parameter logic [LFSR_WIDTH-1:0] SEED        = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   step,
   input  logic [PIXEL_WIDTH-1:0] pixel,
   output logic                   spike
);

   logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;

   always_comb begin
      pixel_d = pixel_q;
      if (load) pixel_d = pixel;
   end

   always_ff @(posedge clk) begin
      if (!rst) pixel_q <= '0;
      else      pixel_q <= pixel_d;
   end

`ifdef SPIKE_ENC_DETERMINISTIC_EN
   logic [PIXEL_WIDTH-1:0] acc_q, acc_d;
   logic [PIXEL_WIDTH:0]   sum;
   logic                   unused_cfg;

   assign unused_cfg = ^SEED;

   // The carry out of acc+pixel is this step's spike; acc keeps the fractional phase.
   assign sum   = {1'b0, acc_q} + {1'b0, pixel_q};
   assign spike = sum[PIXEL_WIDTH];

   always_comb begin
      acc_d = acc_q;
      if (load)      acc_d = '0;
      else if (step) acc_d = sum[PIXEL_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   end
`else
   localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));

   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_adv;

   assign lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
   // Only the low PIXEL_WIDTH bits act as the random threshold; pixel 0 can never win.
   assign spike    = (lfsr_q[PIXEL_WIDTH-1:0] < pixel_q);

   always_comb begin
      lfsr_d = lfsr_q;
      if (load)      lfsr_d = SEED;
      else if (step) lfsr_d = lfsr_adv;
   end

   always_ff @(posedge clk) begin
      if (!rst) lfsr_q <= SEED;
      else      lfsr_q <= lfsr_d;
   end
`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - rate-coding encoder: latched pixel vector to NUM_TIMESTEPS spike vectors
// Ports: clk, rst (sync active-low), bus (spike_rate_encoder_if.slave: image load handshake,
//        spike stream handshake, neuron_clear and done pulses).
// Build option: SPIKE_ENC_DETERMINISTIC_EN switches every lane to the phase-accumulator generator.
module spike_rate_encoder
   import snn_pkg::*;
#(
   parameter int                    NUM_INPUTS    = 4,
   parameter int                    PIXEL_WIDTH   = 8,
   parameter int                    NUM_TIMESTEPS = 16,
   parameter int                    LFSR_WIDTH    = 16,
   parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   spike_rate_encoder_if.slave  bus
);

   localparam int STEP_W = clog2(NUM_TIMESTEPS + 1);

   enc_state_t            state_q, state_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic                  clear_q, clear_d;
   logic                  done_q, done_d;
   logic                  load_fire;
   logic                  step_fire;
   logic                  last_step;
   logic [NUM_INPUTS-1:0] lane_spike;

   assign load_fire = (state_q == IDLE) && bus.load_valid;
   assign step_fire = (state_q == ENCODE) && bus.spike_ready;
   assign last_step = (step_q == STEP_W'(NUM_TIMESTEPS - 1));

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      clear_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_fire) begin
               state_d = ENCODE;
               step_d  = '0;
               clear_d = 1'b1;
            end
         end
         ENCODE: begin
            if (step_fire) begin
               if (last_step) begin
                  state_d = IDLE;
                  step_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         clear_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         clear_q <= clear_d;
         done_q  <= done_d;
      end
   end

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      spike_lane_gen #(
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .LFSR_WIDTH  (LFSR_WIDTH),
         .SEED        (LFSR_SEED ^ LFSR_WIDTH'(i + 1))
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .load  (load_fire),
         .step  (step_fire),
         .pixel (bus.pixel_in[i*PIXEL_WIDTH +: PIXEL_WIDTH]),
         .spike (lane_spike[i])
      );
   end

   // Lane outputs depend only on lane registers, so the gated vector is stable for a whole cycle.
   assign bus.load_ready   = (state_q == IDLE);
   assign bus.spike_valid  = (state_q == ENCODE);
   assign bus.spike_out    = (state_q == ENCODE) ? lane_spike : '0;
   assign bus.neuron_clear = clear_q;
   assign bus.done         = done_q;

endmodule
